// File: rtl/decode_hazard_ctrl.sv
// decode_hazard_ctrl
// Scoreboard hazard controller for the decode stage of a 5-stage pipeline.
// It tracks the destination registers of in-flight writers in EX, MEM and WB.
// It stalls decode on a pending source read, sequences the HALT drain, and
// counts stall cycles with saturation.
//
// Optional build macro HAZ_RF_BYPASS_EN: the register file forwards
// write-before-read, so an instruction in WB no longer causes a stall.
module decode_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [2:0]       id_rs,
    input  logic             id_rs_used,
    input  logic [2:0]       id_rt,
    input  logic             id_rt_used,
    input  logic [2:0]       id_wsel,
    input  logic             id_regwrite,
    input  logic             id_halt,
    input  logic             flush,
    output logic             stall,
    output logic [7:0]       pend_mask,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } haltState_t;

    haltState_t haltState;

    // Tracking slots: valid bit plus destination register
    logic       exV, memV, wbV;
    logic [2:0] exRd, memRd, wbRd;

    // HALT token travelling alongside the slots
    logic tokEx, tokMem, tokWb;

    logic       halting;
    logic       issue;
    logic       hitEx, hitMem, wbStall;
    logic       nextExV, nextMemV, nextWbV;
    logic [2:0] nextExRd, nextMemRd, nextWbRd;
    logic [7:0] nextPend;

    // A slot hit: a valid writer whose destination matches a source that is actually read
    function automatic logic srcHit(
        input logic       v,
        input logic [2:0] rd,
        input logic [2:0] rs,
        input logic       rsUsed,
        input logic [2:0] rt,
        input logic       rtUsed
    );
        return v & ((rsUsed & (rd == rs)) | (rtUsed & (rd == rt)));
    endfunction

    assign halting = (haltState != IDLE);

    // Hazard detection, issue decision and next slot contents
    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        hitEx     = srcHit(exV,  exRd,  id_rs, id_rs_used, id_rt, id_rt_used);
        hitMem    = srcHit(memV, memRd, id_rs, id_rs_used, id_rt, id_rt_used);
`ifdef HAZ_RF_BYPASS_EN
        wbStall   = 1'b0;
`else
        wbStall   = srcHit(wbV,  wbRd,  id_rs, id_rs_used, id_rt, id_rt_used);
`endif
        // A redirect squashes the decode instruction, so it can never stall
        stall     = id_valid & ~flush & (hitEx | hitMem | wbStall);
        issue     = id_valid & ~stall & ~flush & ~halting;

        nextExV   = 1'b0;
        nextExRd  = 3'd0;
        if (issue) begin
            nextExV  = id_regwrite;
            nextExRd = id_wsel;
        end

        // A flushed EX instruction is dropped instead of moving into MEM
        nextMemV  = exV & ~flush;
        nextMemRd = flush ? 3'd0 : exRd;
        nextWbV   = memV;
        nextWbRd  = memRd;

        nextPend  = 8'd0;
        if (nextExV)  nextPend[nextExRd]  = 1'b1;
        if (nextMemV) nextPend[nextMemRd] = 1'b1;
        if (nextWbV)  nextPend[nextWbRd]  = 1'b1;
    end

    // Slot shift register and the pending mask taken after the shift
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            exV       <= 1'b0;
            exRd      <= 3'd0;
            memV      <= 1'b0;
            memRd     <= 3'd0;
            wbV       <= 1'b0;
            wbRd      <= 3'd0;
            pend_mask <= 8'd0;
        end else begin
            exV       <= nextExV;
            exRd      <= nextExRd;
            memV      <= nextMemV;
            memRd     <= nextMemRd;
            wbV       <= nextWbV;
            wbRd      <= nextWbRd;
            pend_mask <= nextPend;
        end
    end

    // HALT sequencing: token shift and IDLE -> DRAIN -> DONE with a sticky halted flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            haltState <= IDLE;
            halted    <= 1'b0;
            tokEx     <= 1'b0;
            tokMem    <= 1'b0;
            tokWb     <= 1'b0;
        end else begin
            tokEx  <= issue & id_halt;
            tokMem <= tokEx & ~flush;
            tokWb  <= tokMem;
            case (haltState)
                IDLE: begin
                    if (issue && id_halt) haltState <= DRAIN;
                end
                DRAIN: begin
                    if (flush && tokEx) begin
                        haltState <= IDLE;
                    end else if (tokWb) begin
                        haltState <= DONE;
                        halted    <= 1'b1;
                    end
                end
                DONE: begin
                    halted <= 1'b1;
                end
                default: begin
                    haltState <= IDLE;
                    halted    <= 1'b0;
                end
            endcase
        end
    end

    // Saturating count of stall cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// Self-checking bench for decode_hazard_ctrl.
// The reference model is a list of in-flight writers tagged by age plus a
// HALT age counter; expected outputs are derived from those each cycle.
module tb_decode_hazard_ctrl;

`ifdef HAZ_RF_BYPASS_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 3;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       id_valid = 1'b0;
    logic [2:0] id_rs = 3'd0;
    logic       id_rs_used = 1'b0;
    logic [2:0] id_rt = 3'd0;
    logic       id_rt_used = 1'b0;
    logic [2:0] id_wsel = 3'd0;
    logic       id_regwrite = 1'b0;
    logic       id_halt = 1'b0;
    logic       flush = 1'b0;

    logic        stall, stallS;
    logic [7:0]  pend_mask, pendS;
    logic        halted, haltedS;
    logic [15:0] stall_cnt;
    logic [3:0]  cntS;

    decode_hazard_ctrl dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
        .id_rt(id_rt), .id_rt_used(id_rt_used), .id_wsel(id_wsel), .id_regwrite(id_regwrite),
        .id_halt(id_halt), .flush(flush), .stall(stall), .pend_mask(pend_mask),
        .halted(halted), .stall_cnt(stall_cnt)
    );

    decode_hazard_ctrl #(.CNT_W(4)) dutSmall (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
        .id_rt(id_rt), .id_rt_used(id_rt_used), .id_wsel(id_wsel), .id_regwrite(id_regwrite),
        .id_halt(id_halt), .flush(flush), .stall(stallS), .pend_mask(pendS),
        .halted(haltedS), .stall_cnt(cntS)
    );

    always #5 clk = ~clk;

    typedef struct {
        int rd;
        int age;
    } flight_t;

    flight_t inFlight[$];
    int      haltAge = -1;
    bit      haltedM = 1'b0;
    longint  stallTotal = 0;
    int      vectors = 0;
    int      miscompares = 0;

    function automatic bit modelStall();
        if (!id_valid || flush) return 1'b0;
        foreach (inFlight[i]) begin
            if (inFlight[i].age < DEPTH &&
                ((id_rs_used && inFlight[i].rd == int'(id_rs)) ||
                 (id_rt_used && inFlight[i].rd == int'(id_rt))))
                return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [7:0] modelPend();
        logic [7:0] m = 8'd0;
        foreach (inFlight[i]) m[inFlight[i].rd] = 1'b1;
        return m;
    endfunction

    task automatic modelReset();
        inFlight.delete();
        haltAge    = -1;
        haltedM    = 1'b0;
        stallTotal = 0;
    endtask

    // Advance the model across one rising edge using the inputs held this cycle
    task automatic modelEdge(input bit expStall);
        flight_t nq[$];
        flight_t f;
        bit issueM;
        issueM = id_valid && !expStall && !flush && !(haltAge >= 0 || haltedM);
        foreach (inFlight[i]) begin
            if (inFlight[i].age == 0 && flush) continue;
            if (inFlight[i].age < 2) begin
                f.rd  = inFlight[i].rd;
                f.age = inFlight[i].age + 1;
                nq.push_back(f);
            end
        end
        if (issueM && id_regwrite) begin
            f.rd  = int'(id_wsel);
            f.age = 0;
            nq.push_back(f);
        end
        inFlight = nq;
        if (haltAge >= 0) begin
            if (flush && haltAge == 0) haltAge = -1;
            else if (haltAge == 2) begin
                haltAge = -1;
                haltedM = 1'b1;
            end else haltAge = haltAge + 1;
        end
        if (issueM && id_halt) haltAge = 0;
        if (expStall) stallTotal = stallTotal + 1;
    endtask

    // One clock: compare the combinational stall mid-cycle, then the registered outputs after the edge
    task automatic runCycle(output logic sawStall);
        logic        expStall;
        logic [7:0]  expPend;
        logic [15:0] exp16;
        logic [3:0]  exp4;
        @(negedge clk);
        expStall = modelStall();
        sawStall = stall;
        vectors++;
        if (stall !== expStall) begin
            miscompares++;
            $display("FAIL stall @%0t: got %b expected %b", $time, stall, expStall);
        end
        vectors++;
        if (stallS !== expStall) begin
            miscompares++;
            $display("FAIL stall_small @%0t: got %b expected %b", $time, stallS, expStall);
        end
        modelEdge(expStall);
        @(posedge clk);
        #1;
        expPend = modelPend();
        exp16   = (stallTotal > 65535) ? 16'hFFFF : 16'(stallTotal);
        exp4    = (stallTotal > 15) ? 4'hF : 4'(stallTotal);
        vectors++;
        if (pend_mask !== expPend || pendS !== expPend) begin
            miscompares++;
            $display("FAIL pend_mask @%0t: got %h/%h expected %h", $time, pend_mask, pendS, expPend);
        end
        vectors++;
        if (halted !== haltedM || haltedS !== haltedM) begin
            miscompares++;
            $display("FAIL halted @%0t: got %b/%b expected %b", $time, halted, haltedS, haltedM);
        end
        vectors++;
        if (stall_cnt !== exp16) begin
            miscompares++;
            $display("FAIL stall_cnt @%0t: got %0d expected %0d", $time, stall_cnt, exp16);
        end
        vectors++;
        if (cntS !== exp4) begin
            miscompares++;
            $display("FAIL stall_cnt4 @%0t: got %0d expected %0d", $time, cntS, exp4);
        end
    endtask

    task automatic setIdle();
        id_valid = 1'b0; id_rs = 3'd0; id_rs_used = 1'b0; id_rt = 3'd0; id_rt_used = 1'b0;
        id_wsel = 3'd0; id_regwrite = 1'b0; id_halt = 1'b0; flush = 1'b0;
    endtask

    task automatic setInstr(input logic [2:0] rs, input logic rsU, input logic [2:0] rt,
                            input logic rtU, input logic [2:0] ws, input logic rw);
        id_valid = 1'b1; id_rs = rs; id_rs_used = rsU; id_rt = rt; id_rt_used = rtU;
        id_wsel = ws; id_regwrite = rw; id_halt = 1'b0; flush = 1'b0;
    endtask

    task automatic drain();
        logic s;
        setIdle();
        for (int i = 0; i < 3; i++) runCycle(s);
    endtask

    // Asynchronous reset applied mid-cycle; outputs must clear before any edge
    task automatic applyReset(input bit withConsumer);
        if (withConsumer) setInstr(3'd1, 1'b1, 3'd2, 1'b1, 3'd0, 1'b0);
        #2 rst = 1'b0;
        #1;
        vectors++;
        if (stall !== 1'b0 || pend_mask !== 8'd0 || halted !== 1'b0 || stall_cnt !== 16'd0 || cntS !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_clear: got stall=%b pend=%h halted=%b cnt=%0d cnt4=%0d expected all zero",
                     stall, pend_mask, halted, stall_cnt, cntS);
        end
        modelReset();
        @(negedge clk);
        setIdle();
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        applyReset(1'b0);
    endtask

    task automatic test_raw();
        logic s;
        int stalls = 0;
        setInstr(3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1);
        runCycle(s);
        setInstr(3'd3, 1'b1, 3'd6, 1'b0, 3'd4, 1'b0);
        for (int i = 0; i < 8; i++) begin
            runCycle(s);
            if (s !== 1'b1) break;
            stalls++;
        end
        vectors++;
        if (stalls != DEPTH) begin
            miscompares++;
            $display("FAIL raw_stall_len: got %0d expected %0d", stalls, DEPTH);
        end
        vectors++;
        if (stall_cnt !== 16'(DEPTH)) begin
            miscompares++;
            $display("FAIL raw_stall_cnt: got %0d expected %0d", stall_cnt, DEPTH);
        end
        drain();
    endtask

    task automatic test_unused();
        logic s;
        setInstr(3'd0, 1'b0, 3'd0, 1'b0, 3'd5, 1'b1);
        runCycle(s);
        vectors++;
        if (pend_mask !== 8'h20) begin
            miscompares++;
            $display("FAIL unused_pend: got %h expected 20", pend_mask);
        end
        setInstr(3'd0, 1'b1, 3'd5, 1'b0, 3'd0, 1'b0);
        runCycle(s);
        vectors++;
        if (s !== 1'b0 || pend_mask !== 8'h20) begin
            miscompares++;
            $display("FAIL unused_operand: got stall=%b pend=%h expected stall=0 pend=20", s, pend_mask);
        end
        drain();
    endtask

    task automatic test_flush();
        logic s;
        setInstr(3'd0, 1'b0, 3'd0, 1'b0, 3'd2, 1'b1);
        runCycle(s);
        setInstr(3'd2, 1'b1, 3'd2, 1'b1, 3'd1, 1'b1);
        runCycle(s);
        vectors++;
        if (s !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_prestall: got %b expected 1", s);
        end
        // Producer now in MEM is not squashed; redo with the producer still in EX
        drain();
        setInstr(3'd0, 1'b0, 3'd0, 1'b0, 3'd2, 1'b1);
        runCycle(s);
        setInstr(3'd2, 1'b1, 3'd2, 1'b1, 3'd1, 1'b1);
        flush = 1'b1;
        runCycle(s);
        vectors++;
        if (s !== 1'b0 || pend_mask[2] !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_wins: got stall=%b pend=%h expected stall=0 bit2=0", s, pend_mask);
        end
        setIdle();
        for (int i = 0; i < 3; i++) begin
            runCycle(s);
            vectors++;
            if (pend_mask[2] !== 1'b0) begin
                miscompares++;
                $display("FAIL flush_squash: got pend=%h expected bit2 clear", pend_mask);
            end
        end
    endtask

    task automatic test_random();
        logic s;
        for (int i = 0; i < 400; i++) begin
            id_valid    = ($urandom_range(0, 3) != 0);
            id_rs       = 3'($urandom_range(0, 7));
            id_rs_used  = 1'($urandom_range(0, 1));
            id_rt       = 3'($urandom_range(0, 7));
            id_rt_used  = 1'($urandom_range(0, 1));
            id_wsel     = 3'($urandom_range(0, 7));
            id_regwrite = ($urandom_range(0, 3) != 0);
            id_halt     = 1'b0;
            flush       = ($urandom_range(0, 7) == 0);
            runCycle(s);
        end
        drain();
    endtask

    task automatic test_reset_midstream();
        logic s;
        setInstr(3'd0, 1'b0, 3'd0, 1'b0, 3'd1, 1'b1);
        runCycle(s);
        setInstr(3'd0, 1'b0, 3'd0, 1'b0, 3'd2, 1'b1);
        runCycle(s);
        setInstr(3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1);
        runCycle(s);
        vectors++;
        if (pend_mask !== 8'h0E) begin
            miscompares++;
            $display("FAIL fill_slots: got %h expected 0e", pend_mask);
        end
        applyReset(1'b1);
        setInstr(3'd6, 1'b1, 3'd1, 1'b1, 3'd7, 1'b1);
        runCycle(s);
        vectors++;
        if (s !== 1'b0 || pend_mask !== 8'h80) begin
            miscompares++;
            $display("FAIL post_reset_issue: got stall=%b pend=%h expected stall=0 pend=80", s, pend_mask);
        end
        drain();
    endtask

    task automatic test_saturation();
        logic s;
        setInstr(3'd4, 1'b1, 3'd4, 1'b1, 3'd4, 1'b1);
        for (int i = 0; i < 45; i++) runCycle(s);
        vectors++;
        if (cntS !== 4'hF) begin
            miscompares++;
            $display("FAIL saturation: got %h expected f", cntS);
        end
        drain();
    endtask

    task automatic test_halt();
        logic s;
        // HALT squashed by a flush while it sits in EX must not halt the pipeline
        setInstr(3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
        id_halt = 1'b1;
        runCycle(s);
        setIdle();
        flush = 1'b1;
        runCycle(s);
        setIdle();
        for (int i = 0; i < 4; i++) runCycle(s);
        setInstr(3'd0, 1'b0, 3'd0, 1'b0, 3'd6, 1'b1);
        runCycle(s);
        vectors++;
        if (halted !== 1'b0 || pend_mask !== 8'h40) begin
            miscompares++;
            $display("FAIL halt_flush_cancel: got halted=%b pend=%h expected halted=0 pend=40", halted, pend_mask);
        end
        drain();
        // Real HALT: later instructions are blocked, halted sets 3 cycles after issue and sticks
        setInstr(3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
        id_halt = 1'b1;
        runCycle(s);
        for (int k = 1; k <= 8; k++) begin
            setInstr(3'd0, 1'b0, 3'd0, 1'b0, 3'(k), 1'b1);
            runCycle(s);
            vectors++;
            if (halted !== (k >= 3) || pend_mask !== 8'd0) begin
                miscompares++;
                $display("FAIL halt_drain k=%0d: got halted=%b pend=%h expected halted=%b pend=00",
                         k, halted, pend_mask, (k >= 3));
            end
        end
        applyReset(1'b1);
    endtask

    initial begin
        setIdle();
        test_reset();
        test_raw();
        test_unused();
        test_flush();
        test_random();
        test_reset_midstream();
        test_saturation();
        test_halt();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Hard time bound so a wedged run still terminates
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1, "timeout");
    end

endmodule
